// File: rtl/fpu_rnd_stage.sv
// Rounding stage after the normalise shifter: applies the IEEE increment to SP words or two-beat DP words.
// Define FPU_RND_DIRECTED_EN to enable the +inf/-inf modes; otherwise they round toward zero and no sign is kept.
module fpu_rnd_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fpuhold,
  input  logic         flush,
  input  logic         in_valid,
  input  logic         dprec,
  input  logic [W-1:0] lsout,
  input  logic         lsround,
  input  logic         stin,
  input  logic         sign,
  input  logic [1:0]   rnd_mode,
  output logic [W-1:0] rnd_hi,
  output logic [W-1:0] rnd_lo,
  output logic         out_valid,
  output logic         expinc,
  output logic         inexact,
  output logic         busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LO_WAIT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [W-1:0] MSB_ONLY = {1'b1, {(W-1){1'b0}}};

`ifdef FPU_RND_DIRECTED_EN
  localparam logic DIR_EN = 1'b1;
`else
  localparam logic DIR_EN = 1'b0;
`endif

  logic [1:0]   r_state;
  logic [W-1:0] r_lo;
  logic         r_g;
  logic         r_s;
  logic [1:0]   r_mode;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_rndLo;
  logic         r_expinc;
  logic         r_inexact;

  logic         w_loWait;
  logic         w_g;
  logic         w_s;
  logic         w_l;
  logic [1:0]   w_mode;
  logic         w_sign;
  logic         w_inc;
  logic [W:0]   w_spSum;
  logic [W:0]   w_loSum;
  logic [W:0]   w_hiSum;

  function automatic logic calcInc(input logic [1:0] mode, input logic g, input logic s,
                                   input logic l, input logic sgn);
    logic inc;
    case (mode)
      2'd0:    inc = g & (s | l);
      2'd2:    inc = DIR_EN & (g | s) & ~sgn;
      2'd3:    inc = DIR_EN & (g | s) & sgn;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  assign w_loWait = (r_state == S_LO_WAIT);

  // On the high DP beat, rounding is decided by what arrived with the low word.
  assign w_g    = w_loWait ? r_g      : lsround;
  assign w_s    = w_loWait ? r_s      : stin;
  assign w_l    = w_loWait ? r_lo[0]  : lsout[0];
  assign w_mode = w_loWait ? r_mode   : rnd_mode;

`ifdef FPU_RND_DIRECTED_EN
  logic r_sign;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign <= 1'b0;
    end else if (!flush && !fpuhold && in_valid && !w_loWait && dprec) begin
      r_sign <= sign;
    end
  end
  assign w_sign = w_loWait ? r_sign : sign;
`else
  logic w_unused;
  assign w_unused = sign;
  assign w_sign   = 1'b0;
`endif

  assign w_inc   = calcInc(w_mode, w_g, w_s, w_l, w_sign);
  assign w_spSum = {1'b0, lsout} + {{W{1'b0}}, w_inc};
  assign w_loSum = {1'b0, r_lo}  + {{W{1'b0}}, w_inc};
  assign w_hiSum = {1'b0, lsout} + {{W{1'b0}}, w_loSum[W]};

  // A DONE state accepts a new first beat directly so results can stream without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lo      <= '0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_mode    <= 2'd0;
      r_hi      <= '0;
      r_rndLo   <= '0;
      r_expinc  <= 1'b0;
      r_inexact <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (!fpuhold) begin
      if (in_valid && !w_loWait) begin
        if (dprec) begin
          r_lo    <= lsout;
          r_g     <= lsround;
          r_s     <= stin;
          r_mode  <= rnd_mode;
          r_state <= S_LO_WAIT;
        end else begin
          r_hi      <= w_spSum[W] ? MSB_ONLY : w_spSum[W-1:0];
          r_rndLo   <= '0;
          r_expinc  <= w_spSum[W];
          r_inexact <= lsround | stin;
          r_state   <= S_DONE;
        end
      end else if (in_valid) begin
        // A DP overflow means both halves wrapped to zero, so the low half stays zero after the shift.
        r_hi      <= w_hiSum[W] ? MSB_ONLY : w_hiSum[W-1:0];
        r_rndLo   <= w_hiSum[W] ? '0 : w_loSum[W-1:0];
        r_expinc  <= w_hiSum[W];
        r_inexact <= r_g | r_s;
        r_state   <= S_DONE;
      end else if (!w_loWait) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign rnd_hi    = r_hi;
  assign rnd_lo    = r_rndLo;
  assign expinc    = r_expinc;
  assign inexact   = r_inexact;
  assign out_valid = (r_state == S_DONE);
  assign busy      = w_loWait;

endmodule

// File: tb/tb_fpu_rnd_stage.sv
// Directed self-checking bench for fpu_rnd_stage; expectations follow FPU_RND_DIRECTED_EN when defined.
module tb_fpu_rnd_stage;

  logic        clk;
  logic        reset;
  logic        fpuhold;
  logic        flush;
  logic        in_valid;
  logic        dprec;
  logic [31:0] lsout;
  logic        lsround;
  logic        stin;
  logic        sign;
  logic [1:0]  rnd_mode;
  logic [31:0] rnd_hi;
  logic [31:0] rnd_lo;
  logic        out_valid;
  logic        expinc;
  logic        inexact;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  fpu_rnd_stage #(.W(32)) dut (
    .clk(clk), .reset(reset), .fpuhold(fpuhold), .flush(flush),
    .in_valid(in_valid), .dprec(dprec), .lsout(lsout), .lsround(lsround),
    .stin(stin), .sign(sign), .rnd_mode(rnd_mode),
    .rnd_hi(rnd_hi), .rnd_lo(rnd_lo), .out_valid(out_valid),
    .expinc(expinc), .inexact(inexact), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs at the falling edge and returns just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic dp, input logic [31:0] data,
                               input logic g, input logic s, input logic sg, input logic [1:0] mode);
    @(negedge clk);
    in_valid = v; dprec = dp; lsout = data; lsround = g; stin = s; sign = sg; rnd_mode = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    testCount++; if (rnd_hi !== 32'h0) begin failCount++; $display("[TB] FAIL reset_hi got %h exp 0", rnd_hi); end
    testCount++; if (rnd_lo !== 32'h0) begin failCount++; $display("[TB] FAIL reset_lo got %h exp 0", rnd_lo); end
    testCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b exp 0", out_valid); end
    testCount++; if (expinc !== 1'b0) begin failCount++; $display("[TB] FAIL reset_expinc got %b exp 0", expinc); end
    testCount++; if (inexact !== 1'b0) begin failCount++; $display("[TB] FAIL reset_inexact got %b exp 0", inexact); end
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_rne_tie;
    applyStimulus(1, 0, 32'h1, 1, 0, 0, 2'd0);
    testCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL odd_valid got %b exp 1", out_valid); end
    testCount++; if (rnd_hi !== 32'h2) begin failCount++; $display("[TB] FAIL odd_hi got %h exp 2", rnd_hi); end
    testCount++; if (inexact !== 1'b1) begin failCount++; $display("[TB] FAIL odd_inexact got %b exp 1", inexact); end
    testCount++; if (expinc !== 1'b0) begin failCount++; $display("[TB] FAIL odd_expinc got %b exp 0", expinc); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
    testCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL odd_pulse got %b exp 0", out_valid); end
    testCount++; if (rnd_hi !== 32'h2) begin failCount++; $display("[TB] FAIL odd_holdhi got %h exp 2", rnd_hi); end
    applyStimulus(1, 0, 32'h2, 1, 0, 0, 2'd0);
    testCount++; if (rnd_hi !== 32'h2) begin failCount++; $display("[TB] FAIL even_hi got %h exp 2", rnd_hi); end
    testCount++; if (inexact !== 1'b1) begin failCount++; $display("[TB] FAIL even_inexact got %b exp 1", inexact); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_overflow;
    applyStimulus(1, 0, 32'hFFFFFFFF, 1, 1, 0, 2'd0);
    testCount++; if (rnd_hi !== 32'h80000000) begin failCount++; $display("[TB] FAIL ovf_hi got %h exp 80000000", rnd_hi); end
    testCount++; if (expinc !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_expinc got %b exp 1", expinc); end
    applyStimulus(1, 0, 32'h4, 0, 1, 0, 2'd1);
    testCount++; if (rnd_hi !== 32'h4) begin failCount++; $display("[TB] FAIL rz_hi got %h exp 4", rnd_hi); end
    testCount++; if (expinc !== 1'b0) begin failCount++; $display("[TB] FAIL rz_expinc got %b exp 0", expinc); end
    testCount++; if (inexact !== 1'b1) begin failCount++; $display("[TB] FAIL rz_inexact got %b exp 1", inexact); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_dp_carry;
    applyStimulus(1, 1, 32'hFFFFFFFF, 1, 1, 0, 2'd0);
    testCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL dp_busy0 got %b exp 1", busy); end
    testCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL dp_valid0 got %b exp 0", out_valid); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
      testCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL dp_busy_idle%0d got %b exp 1", i, busy); end
    end
    applyStimulus(1, 0, 32'h00001234, 0, 0, 0, 2'd1);
    testCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL dp_valid got %b exp 1", out_valid); end
    testCount++; if (rnd_hi !== 32'h00001235) begin failCount++; $display("[TB] FAIL dp_hi got %h exp 00001235", rnd_hi); end
    testCount++; if (rnd_lo !== 32'h0) begin failCount++; $display("[TB] FAIL dp_lo got %h exp 0", rnd_lo); end
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL dp_busy1 got %b exp 0", busy); end
    testCount++; if (inexact !== 1'b1) begin failCount++; $display("[TB] FAIL dp_inexact got %b exp 1", inexact); end
    applyStimulus(1, 1, 32'h00000010, 1, 0, 0, 2'd0);
    applyStimulus(1, 0, 32'hABCD0000, 1, 1, 0, 2'd0);
    testCount++; if (rnd_lo !== 32'h00000010) begin failCount++; $display("[TB] FAIL dp_even_lo got %h exp 00000010", rnd_lo); end
    testCount++; if (rnd_hi !== 32'hABCD0000) begin failCount++; $display("[TB] FAIL dp_even_hi got %h exp ABCD0000", rnd_hi); end
    applyStimulus(1, 1, 32'hFFFFFFFF, 1, 1, 0, 2'd0);
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 2'd0);
    testCount++; if (rnd_hi !== 32'h80000000) begin failCount++; $display("[TB] FAIL dpovf_hi got %h exp 80000000", rnd_hi); end
    testCount++; if (rnd_lo !== 32'h0) begin failCount++; $display("[TB] FAIL dpovf_lo got %h exp 0", rnd_lo); end
    testCount++; if (expinc !== 1'b1) begin failCount++; $display("[TB] FAIL dpovf_expinc got %b exp 1", expinc); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_directed;
    logic [31:0] expNeg;
`ifdef FPU_RND_DIRECTED_EN
    expNeg = 32'h11;
`else
    expNeg = 32'h10;
`endif
    applyStimulus(1, 0, 32'h10, 0, 1, 1, 2'd3);
    testCount++; if (rnd_hi !== expNeg) begin failCount++; $display("[TB] FAIL mode3_hi got %h exp %h", rnd_hi, expNeg); end
    testCount++; if (inexact !== 1'b1) begin failCount++; $display("[TB] FAIL mode3_inexact got %b exp 1", inexact); end
    applyStimulus(1, 0, 32'h10, 0, 1, 1, 2'd2);
    testCount++; if (rnd_hi !== 32'h10) begin failCount++; $display("[TB] FAIL mode2_hi got %h exp 10", rnd_hi); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_back_to_back;
    applyStimulus(1, 0, 32'h1, 1, 0, 0, 2'd0);
    testCount++; if (rnd_hi !== 32'h2 || out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_first got %h/%b exp 2/1", rnd_hi, out_valid); end
    applyStimulus(1, 0, 32'h7, 0, 0, 0, 2'd0);
    testCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid got %b exp 1", out_valid); end
    testCount++; if (rnd_hi !== 32'h7) begin failCount++; $display("[TB] FAIL b2b_hi got %h exp 7", rnd_hi); end
    testCount++; if (inexact !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_inexact got %b exp 0", inexact); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_hold;
    applyStimulus(1, 0, 32'h3, 0, 0, 0, 2'd0);
    @(negedge clk);
    fpuhold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h55, 1, 1, 0, 2'd0);
      testCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL hold_valid%0d got %b exp 1", i, out_valid); end
      testCount++; if (rnd_hi !== 32'h3) begin failCount++; $display("[TB] FAIL hold_hi%0d got %h exp 3", i, rnd_hi); end
    end
    @(negedge clk);
    fpuhold = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
    testCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL hold_release got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_lowait;
    applyStimulus(1, 1, 32'hDEADBEEF, 1, 1, 0, 2'd0);
    testCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL rlw_busy got %b exp 1", busy); end
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL rlw_busy_after got %b exp 0", busy); end
    applyStimulus(1, 0, 32'h5, 0, 0, 0, 2'd0);
    testCount++; if (rnd_hi !== 32'h5) begin failCount++; $display("[TB] FAIL rlw_hi got %h exp 5", rnd_hi); end
    testCount++; if (rnd_lo !== 32'h0) begin failCount++; $display("[TB] FAIL rlw_lo got %h exp 0", rnd_lo); end
    applyStimulus(0, 0, 32'h0, 0, 0, 0, 2'd0);
  endtask

  task automatic test_flush;
    applyStimulus(1, 1, 32'h12345678, 0, 0, 0, 2'd0);
    @(negedge clk);
    flush = 1'b1; fpuhold = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b0; fpuhold = 1'b0;
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL flush_busy got %b exp 0", busy); end
    applyStimulus(1, 0, 32'h8, 1, 0, 0, 2'd0);
    testCount++; if (rnd_hi !== 32'h8) begin failCount++; $display("[TB] FAIL flush_hi got %h exp 8", rnd_hi); end
    testCount++; if (rnd_lo !== 32'h0) begin failCount++; $display("[TB] FAIL flush_lo got %h exp 0", rnd_lo); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b0;
    testCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL flush_valid got %b exp 0", out_valid); end
  endtask

  initial begin
    reset = 1'b0; fpuhold = 1'b0; flush = 1'b0; in_valid = 1'b0; dprec = 1'b0;
    lsout = 32'h0; lsround = 1'b0; stin = 1'b0; sign = 1'b0; rnd_mode = 2'd0;
    test_reset();
    test_rne_tie();
    test_overflow();
    test_dp_carry();
    test_directed();
    test_back_to_back();
    test_hold();
    test_reset_lowait();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
